// File: rtl/sram_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_frame_writer_pkg
// Description : Shared frame geometry, pixel record and write-FSM encoding
//               for the SRAM frame writer.
// Revision    : 1.0  initial release
// ============================================================================
package sram_frame_writer_pkg;

  localparam int H_ACT      = 640;
  localparam int V_ACT      = 480;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W      = 19;
  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;

  // One buffered pixel: frame-start flag plus 10-bit RGB.
  typedef struct packed {
    logic       sof;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  // Low SRAM word carries the upper green bits with blue.
  function automatic logic [DATA_W-1:0] lo_word(input pixel_t p);
    return {1'b0, p.g[9:5], p.b};
  endfunction

  // High SRAM word carries the lower green bits with red.
  function automatic logic [DATA_W-1:0] hi_word(input pixel_t p);
    return {1'b0, p.g[4:0], p.r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_frame_writer_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous pixel FIFO with registered full/empty flags and
//               a combinational head read (head is stable until popped).
// Revision    : 1.0  initial release
// ============================================================================
module pixel_fifo
  import sram_frame_writer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  pixel_t                 push_data,
  input  logic                   pop,
  output pixel_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                PW      = $clog2(DEPTH);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);
  localparam logic [PW:0]       CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]       CNT_MAX = (PW + 1)'(DEPTH);

  pixel_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Storage array; contents need no reset since flags guard every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
      empty <= (count_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : sram_frame_writer
// Description : Buffers incoming RGB pixels and writes each one as two
//               16-bit words into a shared SRAM at 2*(640*Y+X) / +1.
// Revision    : 1.0  initial release
// ============================================================================
module sram_frame_writer
  import sram_frame_writer_pkg::*;
#(
  parameter int FRAME_W = H_ACT,
  parameter int FRAME_H = V_ACT
) (
  input  logic              CLK_50,
  input  logic              RST_N,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [9:0]        i_r,
  input  logic [9:0]        i_g,
  input  logic [9:0]        i_b,
  input  logic              i_sof,
  output logic              o_req,
  input  logic              i_gnt,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_frame_done
);

  localparam int                    XW        = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int                    YW        = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [XW-1:0]         X_LAST    = XW'(FRAME_W - 1);
  localparam logic [YW-1:0]         Y_LAST    = YW'(FRAME_H - 1);
  localparam logic [XW-1:0]         X_ONE     = XW'(1);
  localparam logic [YW-1:0]         Y_ONE     = YW'(1);
  localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
  localparam logic [FIFO_CNT_W-1:0] LEVEL_ONE = FIFO_CNT_W'(1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    active;
  logic [XW-1:0]           x_cnt;
  logic [YW-1:0]           y_cnt;
  logic [IDX_W-1:0]        idx;
  pixel_t                  in_pix;
  pixel_t                  head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_CNT_W-1:0]   fifo_level;
  logic                    push_acc;
  logic                    hi_write;
  logic [XW-1:0]           base_x;
  logic [YW-1:0]           base_y;
  logic [IDX_W-1:0]        base_idx;
  logic                    line_end;
  logic                    frame_end;

  assign in_pix   = {i_sof, i_r, i_g, i_b};
  // active keeps o_ready low through the reset cycle itself.
  assign o_ready  = active && !fifo_full;
  assign push_acc = i_valid && o_ready;
  assign hi_write = (state == WR_HI) && i_gnt;

  // A start-of-frame pixel overrides the running position with (0,0).
  assign base_x    = head.sof ? '0 : x_cnt;
  assign base_y    = head.sof ? '0 : y_cnt;
  assign base_idx  = head.sof ? '0 : idx;
  assign line_end  = (base_x == X_LAST);
  assign frame_end = line_end && (base_y == Y_LAST);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_50),
    .rst_n     (RST_N),
    .push      (push_acc),
    .push_data (in_pix),
    .pop       (hi_write),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Write-sequencer state register.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and SRAM bus drive; strobe only asserted in granted cycles.
  always_comb begin
    state_nxt   = state;
    o_req       = 1'b0;
    o_sram_we_n = 1'b1;
    o_sram_addr = '0;
    o_sram_dq   = '0;
    case (state)
      IDLE: begin
        o_req = !fifo_empty;
        if (!fifo_empty) state_nxt = WR_LO;
      end
      WR_LO: begin
        o_req       = 1'b1;
        o_sram_we_n = !i_gnt;
        o_sram_addr = {base_idx, 1'b0};
        o_sram_dq   = lo_word(head);
        if (i_gnt) state_nxt = WR_HI;
      end
      WR_HI: begin
        o_req       = 1'b1;
        o_sram_we_n = !i_gnt;
        o_sram_addr = {base_idx, 1'b1};
        o_sram_dq   = hi_word(head);
        // Occupancy after the pop: anything beyond the head, or a new push.
        if (i_gnt) begin
          state_nxt = ((fifo_level > LEVEL_ONE) || push_acc) ? WR_LO : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position, linear index and end-of-frame pulse.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      active       <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      idx          <= '0;
      o_frame_done <= 1'b0;
    end else begin
      active       <= 1'b1;
      o_frame_done <= hi_write && frame_end;
      if (hi_write) begin
        if (line_end) begin
          x_cnt <= '0;
          if (frame_end) begin
            y_cnt <= '0;
            idx   <= '0;
          end else begin
            y_cnt <= base_y + Y_ONE;
            idx   <= base_idx + IDX_ONE;
          end
        end else begin
          x_cnt <= base_x + X_ONE;
          idx   <= base_idx + IDX_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_frame_writer
// Description : Scoreboard bench for sram_frame_writer on a reduced 16x4
//               frame so a complete frame and its wrap fit a short run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_frame_writer;

  localparam int TW   = 16;
  localparam int TH   = 4;
  localparam int NPIX = TW * TH;

  logic        CLK_50 = 1'b0;
  logic        RST_N  = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sof   = 1'b0;
  logic        i_gnt   = 1'b0;
  logic [9:0]  i_r = '0;
  logic [9:0]  i_g = '0;
  logic [9:0]  i_b = '0;
  logic        o_ready;
  logic        o_req;
  logic        o_sram_we_n;
  logic        o_frame_done;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;

  int          errors = 0;
  int          checks = 0;
  int          writes = 0;
  int          fd_cnt = 0;
  int          model_idx = 0;
  logic [19:0] last_addr = '0;
  logic [35:0] exp_q[$];

  always #10 CLK_50 = ~CLK_50;

  sram_frame_writer #(
    .FRAME_W (TW),
    .FRAME_H (TH)
  ) dut (
    .CLK_50       (CLK_50),
    .RST_N        (RST_N),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .i_sof        (i_sof),
    .o_req        (o_req),
    .i_gnt        (i_gnt),
    .o_sram_addr  (o_sram_addr),
    .o_sram_dq    (o_sram_dq),
    .o_sram_we_n  (o_sram_we_n),
    .o_frame_done (o_frame_done)
  );

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobed SRAM cycle is matched against the scoreboard.
  always @(negedge CLK_50) begin
    if (RST_N && o_frame_done) begin
      fd_cnt++;
      chk("frame_done_follows_last_write", {16'd0, last_addr}, 36'(2 * NPIX - 1));
    end
    if (RST_N && !o_sram_we_n) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 o_sram_addr, o_sram_dq);
      end else begin
        chk("sram_write", {o_sram_addr, o_sram_dq}, exp_q.pop_front());
      end
      last_addr = o_sram_addr;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  // Expected pair of writes for a pixel at the reference raster position.
  task automatic expect_pixel(input logic sof, input logic [9:0] r, input logic [9:0] g,
                              input logic [9:0] b);
    if (sof) model_idx = 0;
    exp_q.push_back({20'(2 * model_idx),     1'b0, g[9:5], b});
    exp_q.push_back({20'(2 * model_idx + 1), 1'b0, g[4:0], r});
    model_idx = (model_idx + 1) % NPIX;
  endtask

  // Offer one pixel until accepted; returns at posedge+1 after acceptance.
  task automatic push_pix(input logic sof, input logic [9:0] r, input logic [9:0] g,
                          input logic [9:0] b);
    int n;
    n = 0;
    i_valid = 1'b1; i_sof = sof; i_r = r; i_g = g; i_b = b;
    @(negedge CLK_50);
    while (!o_ready && n < 200) begin
      n++;
      @(negedge CLK_50);
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got o_ready=0 for 200 cycles, want 1");
    end else begin
      expect_pixel(sof, r, g, b);
    end
    @(posedge CLK_50);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_req) && n < 3000) begin
      step(1);
      n++;
    end
    chk("drain_pending_writes", 36'(exp_q.size()), 36'd0);
    step(1);
  endtask

  initial begin
    int w0;
    int fd0;
    int accepted;
    logic rdy;

    // Reset state
    RST_N = 1'b0;
    step(3);
    @(negedge CLK_50);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_req", o_req, 1'b0);
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_addr", o_sram_addr, 20'h0);
    chk("rst_dq", o_sram_dq, 16'h0);
    chk("rst_frame_done", o_frame_done, 1'b0);
    @(posedge CLK_50); #1;
    RST_N = 1'b1;
    step(2);
    @(negedge CLK_50);
    chk("ready_after_reset", o_ready, 1'b1);
    @(posedge CLK_50); #1;

    // Single sof pixel, hand-computed words, two-cycle latency
    i_gnt = 1'b1;
    w0 = writes;
    exp_q.push_back({20'h00000, 16'h5401});
    exp_q.push_back({20'h00001, 16'h17FF});
    model_idx = 1;
    i_valid = 1'b1; i_sof = 1'b1; i_r = 10'h3FF; i_g = 10'h2A5; i_b = 10'h001;
    @(negedge CLK_50);
    chk("single_ready", o_ready, 1'b1);
    @(posedge CLK_50); #1;
    i_valid = 1'b0; i_sof = 1'b0;
    @(negedge CLK_50);
    chk("latency_c1_we_n", o_sram_we_n, 1'b1);
    chk("latency_c1_req", o_req, 1'b1);
    @(negedge CLK_50);
    chk("latency_c2_we_n", o_sram_we_n, 1'b0);
    @(posedge CLK_50); #1;
    wait_drain();
    chk("single_write_count", 36'(writes - w0), 36'd2);

    // Nine back-to-back pushes without grant: eight fit
    i_gnt = 1'b0;
    w0 = writes;
    accepted = 0;
    rdy = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_r = 10'(k * 37 + 5); i_g = 10'(341 ^ (k * 9)); i_b = 10'(k * 64);
      @(negedge CLK_50);
      rdy = o_ready;
      if (rdy) begin
        accepted++;
        expect_pixel(1'b0, i_r, i_g, i_b);
      end
      @(posedge CLK_50); #1;
    end
    i_valid = 1'b0;
    chk("fill_accepted", 36'(accepted), 36'd8);
    chk("fill_ready_last", rdy, 1'b0);
    @(negedge CLK_50);
    chk("fill_ready_full", o_ready, 1'b0);
    chk("fill_req", o_req, 1'b1);
    chk("fill_no_writes", 36'(writes - w0), 36'd0);
    @(posedge CLK_50); #1;
    i_gnt = 1'b1;
    wait_drain();
    @(negedge CLK_50);
    chk("drained_ready", o_ready, 1'b1);
    @(posedge CLK_50); #1;

    // Grant toggling 1,0,1 through one pixel
    i_gnt = 1'b0;
    w0 = writes;
    push_pix(1'b0, 10'h0AA, 10'h155, 10'h2CC);
    step(1);
    i_gnt = 1'b1;
    @(negedge CLK_50);
    chk("toggle_lo_we_n", o_sram_we_n, 1'b0);
    @(posedge CLK_50); #1;
    i_gnt = 1'b0;
    @(negedge CLK_50);
    chk("toggle_gap_we_n", o_sram_we_n, 1'b1);
    chk("toggle_gap_req", o_req, 1'b1);
    @(posedge CLK_50); #1;
    i_gnt = 1'b1;
    @(negedge CLK_50);
    chk("toggle_hi_we_n", o_sram_we_n, 1'b0);
    @(posedge CLK_50); #1;
    i_gnt = 1'b0;
    step(2);
    chk("toggle_write_count", 36'(writes - w0), 36'd2);
    @(negedge CLK_50);
    chk("toggle_idle_req", o_req, 1'b0);
    @(posedge CLK_50); #1;

    // sof arriving mid-stream restarts addressing at 0
    i_gnt = 1'b1;
    for (int k = 0; k < 5; k++) push_pix(1'b0, 10'(k + 1), 10'(k * 3), 10'(k * 5));
    push_pix(1'b1, 10'h111, 10'h222, 10'h333);
    push_pix(1'b0, 10'h044, 10'h055, 10'h066);
    wait_drain();

    // Complete frame, then wrap back to the origin
    fd0 = fd_cnt;
    push_pix(1'b1, 10'h3FF, 10'h000, 10'h3FF);
    for (int k = 1; k < NPIX; k++) push_pix(1'b0, 10'(k), 10'(k * 7), 10'(1023 - k));
    wait_drain();
    chk("frame_done_once", 36'(fd_cnt - fd0), 36'd1);
    push_pix(1'b0, 10'h123, 10'h321, 10'h0F0);
    wait_drain();
    chk("frame_done_no_repeat", 36'(fd_cnt - fd0), 36'd1);

    // Reset during the high-word write with five pixels behind the head
    i_gnt = 1'b0;
    for (int k = 0; k < 6; k++) push_pix(1'b0, 10'(k + 9), 10'(k + 20), 10'(k + 40));
    i_gnt = 1'b1;
    @(negedge CLK_50);
    @(posedge CLK_50); #1;
    RST_N = 1'b0;
    @(posedge CLK_50); #1;
    @(negedge CLK_50);
    chk("abort_we_n", o_sram_we_n, 1'b1);
    chk("abort_req", o_req, 1'b0);
    chk("abort_ready", o_ready, 1'b0);
    @(posedge CLK_50); #1;
    RST_N = 1'b1;
    exp_q.delete();
    model_idx = 0;
    w0 = writes;
    step(4);
    chk("abort_discarded", 36'(writes - w0), 36'd0);
    @(negedge CLK_50);
    chk("abort_fifo_empty_req", o_req, 1'b0);
    @(posedge CLK_50); #1;
    push_pix(1'b0, 10'h2AB, 10'h1CD, 10'h0EF);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2 ms, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sram_frame_writer.md
SRAM_FRAME_WRITER -- requirements
Module: sram_frame_writer

Interface
REQ-001 H_ACT, 640, active pixels per line.
REQ-002 V_ACT, 480, active lines per frame.
REQ-003 FIFO_DEPTH, 8, pixel buffer entries (power of two).
REQ-004 CLK_50  in  1  sole clock; all logic on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 i_valid  in  1  input pixel valid.
REQ-007 o_ready  out  1  pixel accepted when i_valid && o_ready.
REQ-008 i_r, i_g, i_b  in  10 each  pixel colour.
REQ-009 i_sof  in  1  marks the pixel as the first of a frame.
REQ-010 o_req  out  1  SRAM bus request.
REQ-011 i_gnt  in  1  SRAM bus granted for the current cycle.
REQ-012 o_sram_addr  out  20  word address.
REQ-013 o_sram_dq  out  16  write data.
REQ-014 o_sram_we_n  out  1  write strobe, active-low.
REQ-015 o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.

Function
REQ-016 An accepted pixel SHALL be pushed as {sof, r, g, b} (31 bits) into the FIFO; o_ready SHALL equal !full, and a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-017 o_req SHALL be high whenever the FIFO is non-empty or the FSM is in WR_LO/WR_HI.
REQ-018 The FSM SHALL have states IDLE, WR_LO, WR_HI: IDLE->WR_LO when the FIFO is non-empty; WR_LO->WR_HI on i_gnt; WR_HI->WR_LO on i_gnt with the FIFO non-empty after the pop, else WR_HI->IDLE on i_gnt; without i_gnt the state SHALL hold.
REQ-019 In WR_LO/WR_HI, o_sram_we_n SHALL be low only in cycles where i_gnt is high; otherwise it SHALL be high.
REQ-020 The word address SHALL be {idx[18:0], lsb}, with idx = 640*Y + X and lsb = 0 in WR_LO, 1 in WR_HI.
REQ-021 Data in WR_LO SHALL be {1'b0, g[9:5], b[9:0]}; data in WR_HI SHALL be {1'b0, g[4:0], r[9:0]}.
REQ-022 The FIFO head SHALL be popped in the WR_HI cycle with i_gnt; the head SHALL stay stable from WR_LO entry until that pop.
REQ-023 X/Y counters SHALL advance after each WR_HI write: X wraps 639->0 and increments Y; Y wraps 479->0.
REQ-024 If the head pixel has sof=1, it SHALL be written at X=0, Y=0 regardless of counter values, and counting SHALL continue from there.
REQ-025 o_frame_done SHALL pulse in the cycle after the WR_HI write of pixel (639, 479).
REQ-026 idx SHALL be registered (incremented by 1 per pixel, reset to 0 at wrap or sof) so that no multiplier exists on the datapath.
REQ-027 Latency from push into an empty FIFO (FSM in IDLE) to the first we_n low SHALL be 2 cycles, given i_gnt is held high.

Reset
REQ-028 While RST_N is low at a clock edge: FIFO empty, FSM IDLE, X=Y=idx=0, o_ready=0, o_req=0, o_sram_we_n=1, o_sram_addr=0, o_sram_dq=0, o_frame_done=0.
REQ-029 A reset mid-write SHALL abort the write immediately (we_n high next cycle) and discard all buffered pixels.

Structure
REQ-030 The shared package SHALL hold H_ACT, V_ACT, the pixel struct {sof, r, g, b}, and the FSM state enum.
REQ-031 The FIFO SHALL be a sub-module named pixel_fifo (synchronous, registered full/empty flags).

Verification
REQ-032 Scenario: one pixel r=0x3FF, g=0x2A5, b=0x001, sof=1, i_gnt=1 -> writes addr 0x00000 data 0x5401, then addr 0x00001 data 0x17FF.
REQ-033 Scenario: 9 pixels pushed back-to-back with i_gnt=0 -> o_ready falls after 8 pushes; no we_n pulses; o_req=1.
REQ-034 Scenario: i_gnt toggles 1,0,1 during a pixel write -> WR_HI holds through the ungranted cycle; we_n is low only in granted cycles; exactly two writes occur.
REQ-035 Scenario: full frame of 307200 pixels, first with sof -> last writes hit 0x95FFE/0x95FFF; o_frame_done pulses once; counters return to 0.
REQ-036 Scenario: sof arrives after 100 pixels -> that pixel writes to 0x00000/0x00001; the following pixel writes to 0x00002.
REQ-037 Scenario: RST_N low during WR_HI with 5 pixels buffered -> next cycle we_n=1, o_req=0, FIFO empty, o_ready=0.
